// File: rtl/mem_bus_master_pkg.sv
// Shared widths, memory depth and state encodings for the memory bus master.
// The STATE_* constants give the FSM encoding used by the RTL and by the bench.
package mem_bus_master_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 3;
    localparam int MEM_DEPTH  = 32;

    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_WR_WAIT   = 3'd1;
    localparam logic [2:0] STATE_WR_STROBE = 3'd2;
    localparam logic [2:0] STATE_RD_ISSUE  = 3'd3;
    localparam logic [2:0] STATE_RD_HOLD   = 3'd4;
    localparam logic [2:0] STATE_FINISH    = 3'd5;
    localparam logic [2:0] STATE_VERIFY    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = STATE_IDLE,
        S_WR_WAIT   = STATE_WR_WAIT,
        S_WR_STROBE = STATE_WR_STROBE,
        S_RD_ISSUE  = STATE_RD_ISSUE,
        S_RD_HOLD   = STATE_RD_HOLD,
        S_FINISH    = STATE_FINISH,
        S_VERIFY    = STATE_VERIFY
    } state_t;

endpackage

// File: rtl/mem_addr_ctr.sv
// Burst address register with modulo-2^ADDR_W increment and remaining-beat down-counter.
// Load and step take effect on the next posedge; last_o is a pure decode of the counter.
module mem_addr_ctr
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = addr_i;
            rem_d  = len_i;
        end else if (step_i) begin
            // Natural overflow of the ADDR_W-bit register gives the address wrap
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Burst initiator for the shared 8-bit memory bus: 2 cycles/beat (3 per write with MEM_BUS_MASTER_VERIFY_EN).
// Commands accepted only in IDLE; write data waits for wd_valid, read data holds until rd_ready.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_adress,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_readen,
    output logic              mem_writen,
    input  logic [DATA_W-1:0] mem_bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              ctr_load, ctr_step, last_beat;

    mem_addr_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_ctr (
        .clk    (clk),
        .reset  (reset),
        .load_i (ctr_load),
        .addr_i (req_addr),
        .len_i  (req_len),
        .step_i (ctr_step),
        .addr_o (mem_adress),
        .last_o (last_beat)
    );

`ifdef MEM_BUS_MASTER_VERIFY_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        mem_data_d = mem_data_q;
        ctr_load   = 1'b0;
        ctr_step   = 1'b0;
        req_ready  = 1'b0;
        wd_ready   = 1'b0;
        rd_valid   = 1'b0;
        done       = 1'b0;
        mem_readen = 1'b0;
        mem_writen = 1'b0;
`ifdef MEM_BUS_MASTER_VERIFY_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ctr_load = 1'b1;
                    state_d  = req_write ? S_WR_WAIT : S_RD_ISSUE;
                end
            end
            S_WR_WAIT: begin
                wd_ready = 1'b1;
                if (wd_valid) begin
                    mem_data_d = wd_data;
                    state_d    = S_WR_STROBE;
                end
            end
            S_WR_STROBE: begin
                mem_writen = 1'b1;
`ifdef MEM_BUS_MASTER_VERIFY_EN
                state_d = S_VERIFY;
`else
                if (last_beat) begin
                    state_d = S_FINISH;
                end else begin
                    ctr_step = 1'b1;
                    state_d  = S_WR_WAIT;
                end
`endif
            end
`ifdef MEM_BUS_MASTER_VERIFY_EN
            S_VERIFY: begin
                // Same address is still on the bus, so this reads back the byte just stored
                mem_readen = 1'b1;
                if (mem_bus != mem_data_q) begin
                    err_d = 1'b1;
                end
                if (last_beat) begin
                    state_d = S_FINISH;
                end else begin
                    ctr_step = 1'b1;
                    state_d  = S_WR_WAIT;
                end
            end
`endif
            S_RD_ISSUE: begin
                mem_readen = 1'b1;
                rd_data_d  = mem_bus;
                state_d    = S_RD_HOLD;
            end
            S_RD_HOLD: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (last_beat) begin
                        state_d = S_FINISH;
                    end else begin
                        ctr_step = 1'b1;
                        state_d  = S_RD_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            mem_data_q <= mem_data_d;
        end
    end

`ifdef MEM_BUS_MASTER_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rd_data  = rd_data_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with a 32-byte behavioural memory on the bus.
module tb_mem_bus_master;
    import mem_bus_master_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int LW = DEF_LEN_W;
`ifdef MEM_BUS_MASTER_VERIFY_EN
    localparam int   WCYC    = 3;
    localparam logic EXP_ERR = 1'b1;
`else
    localparam int   WCYC    = 2;
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wd_valid = 1'b0;
    logic [DW-1:0] wd_data = '0;
    logic          rd_ready = 1'b0;
    logic          req_ready, wd_ready, rd_valid, done, err, mem_readen, mem_writen;
    logic [DW-1:0] rd_data, mem_data, mem_bus;
    logic [AW-1:0] mem_adress;

    logic [DW-1:0] mem [MEM_DEPTH];
    logic          force_zero = 1'b0;

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0;
    int done_cnt = 0, wr_cnt = 0, rds_cnt = 0, both_cnt = 0;

    always #5 clk = ~clk;

    mem_bus_master dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .wd_data    (wd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .done       (done),
        .err        (err),
        .mem_adress (mem_adress),
        .mem_data   (mem_data),
        .mem_readen (mem_readen),
        .mem_writen (mem_writen),
        .mem_bus    (mem_bus)
    );

    // Undriven bus shows a junk pattern so any capture outside a read strobe is visible
    assign mem_bus = !mem_readen ? 8'hEE : (force_zero ? 8'h00 : mem[mem_adress]);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (!reset) begin
            if (req_valid && req_ready) acc_cyc <= cyc;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (mem_writen) begin
                wr_cnt <= wr_cnt + 1;
                mem[mem_adress] <= mem_data;
            end
            if (mem_readen) rds_cnt <= rds_cnt + 1;
            if (mem_readen && mem_writen) both_cnt <= both_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] b, input int stall);
        int n;
        wd_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("wstall_writen", mem_writen, 0);
            chk("wstall_req_ready", req_ready, 0);
            chk("wstall_wd_ready", wd_ready, 1);
            @(negedge clk);
        end
        wd_valid = 1'b1;
        wd_data  = b;
        n = 0;
        while (!wd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wd_ready) chk("wd_ready_timeout", 0, 1);
        @(negedge clk);
        wd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d [8]);
        issue_req(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) send_beat(d[i], 0);
        wait_done("wr");
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d [8],
                              input int stall);
        int n, s0;
        issue_req(1'b0, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            n = 0;
            while (!rd_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!rd_valid) chk("rd_valid_timeout", 0, 1);
            chk($sformatf("rd_data_beat%0d", i), rd_data, d[i]);
            if (i == 0 && stall > 0) begin
                s0 = rds_cnt;
                for (int j = 0; j < stall; j++) begin
                    @(negedge clk);
                    chk("stall_rd_valid", rd_valid, 1);
                    chk("stall_rd_data", rd_data, d[i]);
                    chk("stall_readen", mem_readen, 0);
                end
                chk("stall_no_reissue", rds_cnt - s0, 0);
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
        wait_done("rd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pat [8];
        int w0, d0, r0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_readen", mem_readen, 0);
        chk("rst_writen", mem_writen, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_adress", mem_adress, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write then single read at address 3
        pat = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        w0 = wr_cnt;
        d0 = done_cnt;
        write_burst(5'd3, 3'd0, pat);
        chk("w1_mem3", mem[3], 8'hA5);
        chk("w1_writen_cycles", wr_cnt - w0, 1);
        chk("w1_done_pulses", done_cnt - d0, 1);
        chk("w1_latency", done_cyc - acc_cyc, WCYC + 1);
        d0 = done_cnt;
        read_burst(5'd3, 3'd0, pat, 0);
        chk("r1_done_pulses", done_cnt - d0, 1);
        chk("r1_latency", done_cyc - acc_cyc, 3);

        // Four-beat write wrapping from 30 to 1
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        write_burst(5'd30, 3'd3, pat);
        chk("wrap_mem30", mem[30], 8'h11);
        chk("wrap_mem31", mem[31], 8'h22);
        chk("wrap_mem0", mem[0], 8'h33);
        chk("wrap_mem1", mem[1], 8'h44);
        chk("wrap_mem2", mem[2], 8'h00);
        chk("wrap_w_latency", done_cyc - acc_cyc, 4 * WCYC + 1);
        read_burst(5'd30, 3'd3, pat, 0);
        chk("wrap_r_latency", done_cyc - acc_cyc, 9);

        // Read backpressure on the first of two beats
        r0 = rds_cnt;
        read_burst(5'd30, 3'd1, pat, 5);
        chk("bp_read_strobes", rds_cnt - r0, 2);

        // Write data withheld for four cycles
        d0 = done_cnt;
        issue_req(1'b1, 5'd5, 3'd0);
        send_beat(8'h3C, 4);
        wait_done("wstall");
        chk("wstall_mem5", mem[5], 8'h3C);
        chk("wstall_done", done_cnt - d0, 1);
        chk("clean_err", err, 0);

        // Reset partway through an eight-beat write
        pat = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
        d0 = done_cnt;
        issue_req(1'b1, 5'd8, 3'd7);
        send_beat(pat[0], 0);
        send_beat(pat[1], 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_writen", mem_writen, 0);
        chk("mid_rst_readen", mem_readen, 0);
        chk("mid_rst_wd_ready", wd_ready, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_mem8", mem[8], 8'h80);
        chk("mid_rst_mem9", mem[9], 8'h81);
        chk("mid_rst_mem10", mem[10], 8'h00);
        chk("mid_rst_mem15", mem[15], 8'h00);

        // Corrupted readback during a write
        pat = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        force_zero = 1'b1;
        write_burst(5'd20, 3'd0, pat);
        force_zero = 1'b0;
        chk("vfy_err_set", err, EXP_ERR);
        chk("vfy_mem20", mem[20], 8'h5A);
        read_burst(5'd20, 3'd0, pat, 0);
        chk("vfy_err_sticky", err, EXP_ERR);
        reset = 1'b1;
        @(negedge clk);
        chk("vfy_err_cleared", err, 0);
        reset = 1'b0;
        @(negedge clk);

        chk("strobe_overlap", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the shared 8-bit memory bus; sequences read and write accesses into the 32-byte, 5-bit-address byte memory.
- Accepts burst commands from a client over valid/ready and drives the memory's adress, data, readen and writen lines.
- Captures read bytes from the memory's tri-state Output bus and returns them to the client over valid/ready.

Parameters:
ADDR_W, 5, memory address width; wraps modulo 2^ADDR_W
DATA_W, 8, data bus width
LEN_W, 3, burst length field width; a burst is req_len+1 beats (1..8)

Ports:
clk  input  1  system clock, all state changes on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
req_valid  input  1  command valid
req_ready  output  1  high only in IDLE
req_write  input  1  1 = write burst, 0 = read burst
req_addr  input  ADDR_W  start address
req_len  input  LEN_W  beats minus one
wd_valid  input  1  write byte valid
wd_ready  output  1  write byte accepted
wd_data  input  DATA_W  write byte
rd_valid  output  1  read byte valid
rd_ready  input  1  client accepts read byte
rd_data  output  DATA_W  read byte
done  output  1  one-cycle pulse at burst end
err  output  1  sticky readback mismatch (see Optional Feature)
mem_adress  output  ADDR_W  memory address
mem_data  output  DATA_W  memory write data
mem_readen  output  1  memory read enable
mem_writen  output  1  memory write enable
mem_bus  input  DATA_W  memory tri-state Output bus

Behaviour:
- Reset: state IDLE, req_ready=1; wd_ready, rd_valid, done, err, mem_readen, mem_writen = 0; rd_data, mem_data, mem_adress = 0.
- Reset mid-burst abandons the burst with no done pulse. Strobes are low from the first post-reset cycle.
- States: IDLE, WR_WAIT, WR_STROBE, RD_ISSUE, RD_HOLD, FINISH.
- IDLE: on req_valid&&req_ready, latch addr into mem_adress and len into beat counter (remaining = req_len). Go to WR_WAIT if req_write, else RD_ISSUE.
- WR_WAIT: wd_ready=1 combinationally. On wd_valid, register wd_data into mem_data and go to WR_STROBE. Holds indefinitely without wd_valid.
- WR_STROBE: mem_writen=1 for exactly one cycle; the memory stores on the posedge ending it. If remaining==0, go to FINISH. Otherwise increment mem_adress, decrement remaining, and go to WR_WAIT.
- RD_ISSUE: mem_readen=1 for exactly one cycle. At the posedge ending it, mem_bus is captured into rd_data; go to RD_HOLD.
- RD_HOLD: rd_valid=1, mem_readen=0, rd_data stable. On rd_ready: if remaining==0 go to FINISH, else increment address, decrement remaining, go to RD_ISSUE.
- FINISH: done=1 for one cycle, then IDLE. req_ready stays 0 in FINISH.
- Latency: minimum 2 cycles per write beat. Read beat is 2 cycles with rd_ready held high. Command accept to done: 2*(len+1)+1 cycles plus stalls.
- Address arithmetic is modulo 2^ADDR_W: 31+1 = 0. Bursts wrap silently.
- mem_readen and mem_writen are never high together. mem_bus is ignored whenever mem_readen=0 (bus is Z).
- mem_adress and mem_data hold their values between strobes; no glitching.

Optional Feature:
- Macro MEM_BUS_MASTER_VERIFY_EN.
- Defined: each WR_STROBE is followed by a VERIFY state that drives mem_readen=1 for one cycle at the same address and compares mem_bus with mem_data. On mismatch, err is set and held until reset. The write beat costs 3 cycles.
- Undefined: VERIFY state is absent and err is tied 0.

Decomposition:
- Shared package/header holds:
  - ADDR_W, DATA_W, LEN_W defaults
  - MEM_DEPTH=32
  - state encodings (3-bit localparams)
  - STATE_* names for the bench
- One natural sub-module, mem_addr_ctr: a loadable address register with wrapping increment plus the remaining-beat down-counter and its last flag.

Test Plan:
- Single write then read: write 0xA5 at addr 3 (len 0), then read addr 3 -> rd_data=0xA5; done pulses once per burst; mem_writen high exactly 1 cycle.
- Wrapping burst: write len 3 at addr 30 with bytes 11,22,33,44 -> memory locations 30,31,0,1 hold them; read-back burst returns the same order.
- Backpressure: read len 1 with rd_ready low for 5 cycles -> rd_valid and rd_data held stable, mem_readen low during stall, second beat issued only after acceptance.
- Write stall: withhold wd_valid 4 cycles in WR_WAIT -> no mem_writen; req_ready stays 0; burst completes after data arrives.
- Reset mid-burst: assert reset during a len-7 write after beat 2 -> next cycle IDLE, all strobes 0, no done; later locations unwritten.
- VERIFY_EN: force mem_bus to 0x00 during the readback of a 0x5A write -> err=1 and stays set until reset; with the macro undefined, err remains 0.
